// File: rtl/pe_pkg.sv
// Shared definitions for the PE-array partial-sum path: default widths,
// the partial-sum word width, and the buffer sequencer state encoding.
package pe_pkg;

    localparam int PE_ARRAY_DIM  = 16;
    localparam int PE_ACC_WIDTH  = 32;
    localparam int PE_ADDR_WIDTH = 10;
    localparam int PE_PASS_WIDTH = 8;
    localparam int PSUM_WORD_W   = PE_ARRAY_DIM * PE_ACC_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACC      = 3'd1,
        ST_BUBBLE   = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_HOLD  = 3'd5,
        ST_DONE     = 3'd6
    } psum_state_e;

endpackage

// File: rtl/psum_addr_counter.sv
// Buffer address pointer: clears to zero, steps on inc and wraps to zero
// at the terminal count (limit-1). The internal register is one bit wider
// than the address so a full 2^ADDR_WIDTH limit compares cleanly.
module psum_addr_counter
    import pe_pkg::*;
#(
    parameter int ADDR_WIDTH = PE_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   limit,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] ptr_r;

    assign last = (ptr_r == (limit - ONE));
    assign ptr  = ptr_r[ADDR_WIDTH-1:0];

    // Pointer register: zero on clr, otherwise step and wrap at terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (clr) begin
            ptr_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (inc) begin
            if (last) begin
                ptr_r <= {(ADDR_WIDTH+1){1'b0}};
            end else begin
                ptr_r <= ptr_r + ONE;
            end
        end
    end

endmodule

// File: rtl/psum_buffer_ctrl.sv
// Partial-sum buffer sequencer. Runs num_pass accumulation passes over
// num_pix buffer addresses (pass 0 overwrites, later passes accumulate),
// then streams every address back out over a valid/ready interface.
// A one-cycle bubble after a single-address pass or the final pass keeps
// reads at least two cycles behind the last write to the same address.
// Optional build macro PSUM_CTRL_PERF_EN adds two saturating stall counters.
module psum_buffer_ctrl
    import pe_pkg::*;
#(
    parameter int ARRAY_DIM  = PE_ARRAY_DIM,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter int ADDR_WIDTH = PE_ADDR_WIDTH,
    parameter int PASS_WIDTH = PE_PASS_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            num_pix,
    input  logic [PASS_WIDTH-1:0]          num_pass,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ADDR_WIDTH-1:0]          buf_addr,
    output logic                           buf_acc_enable,
    output logic                           buf_acc_clear,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_final_out,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_addr
`ifdef PSUM_CTRL_PERF_EN
    ,
    output logic [31:0]                    perf_acc_stall,
    output logic [31:0]                    perf_out_stall
`endif
);

    localparam int WORD_W = ARRAY_DIM * ACC_WIDTH;
    localparam logic [ADDR_WIDTH:0]   NPIX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PASS_WIDTH-1:0] PASS_ONE = {{(PASS_WIDTH-1){1'b0}}, 1'b1};

    psum_state_e           state_r;
    psum_state_e           state_nxt_s;
    logic [ADDR_WIDTH:0]   num_pix_r;
    logic [PASS_WIDTH-1:0] num_pass_r;
    logic [PASS_WIDTH-1:0] pass_cnt_r;
    logic                  rd_next_r;
    logic                  rd_next_nxt_s;
    logic [WORD_W-1:0]     out_data_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic                  out_valid_r;

    logic [ADDR_WIDTH-1:0] wr_ptr_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_s;
    logic                  wr_last_s;
    logic                  rd_last_s;
    logic                  wr_clr_s;
    logic                  wr_inc_s;
    logic                  rd_clr_s;
    logic                  rd_inc_s;
    logic                  start_ok_s;
    logic                  last_pass_s;
    logic                  one_pix_s;

    assign start_ok_s  = start && (num_pix != {(ADDR_WIDTH+1){1'b0}})
                               && (num_pass != {PASS_WIDTH{1'b0}});
    assign last_pass_s = (pass_cnt_r == (num_pass_r - PASS_ONE));
    assign one_pix_s   = (num_pix_r == NPIX_ONE);

    psum_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (wr_clr_s),
        .inc   (wr_inc_s),
        .limit (num_pix_r),
        .ptr   (wr_ptr_s),
        .last  (wr_last_s)
    );

    psum_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (rd_clr_s),
        .inc   (rd_inc_s),
        .limit (num_pix_r),
        .ptr   (rd_ptr_s),
        .last  (rd_last_s)
    );

    // State and bubble-destination flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rd_next_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rd_next_r <= rd_next_nxt_s;
        end
    end

    // Next-state logic and pointer control
    always_comb begin
        state_nxt_s   = state_r;
        rd_next_nxt_s = rd_next_r;
        wr_clr_s      = 1'b0;
        wr_inc_s      = 1'b0;
        rd_clr_s      = 1'b0;
        rd_inc_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    wr_clr_s    = 1'b1;
                    rd_clr_s    = 1'b1;
                    state_nxt_s = ST_ACC;
                end else if (start) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    wr_inc_s = 1'b1;
                    if (wr_last_s && last_pass_s) begin
                        rd_next_nxt_s = 1'b1;
                        state_nxt_s   = ST_BUBBLE;
                    end else if (wr_last_s && one_pix_s) begin
                        rd_next_nxt_s = 1'b0;
                        state_nxt_s   = ST_BUBBLE;
                    end else begin
                        state_nxt_s = ST_ACC;
                    end
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_BUBBLE: begin
                if (rd_next_r) begin
                    state_nxt_s = ST_RD_ISSUE;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_RD_ISSUE: state_nxt_s = ST_RD_WAIT;
            ST_RD_WAIT:  state_nxt_s = ST_RD_HOLD;
            ST_RD_HOLD: begin
                if (out_ready && rd_last_s) begin
                    state_nxt_s = ST_DONE;
                end else if (out_ready) begin
                    rd_inc_s    = 1'b1;
                    state_nxt_s = ST_RD_ISSUE;
                end else begin
                    state_nxt_s = ST_RD_HOLD;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Job configuration latch and pass counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_pix_r  <= {(ADDR_WIDTH+1){1'b0}};
            num_pass_r <= {PASS_WIDTH{1'b0}};
            pass_cnt_r <= {PASS_WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && start_ok_s) begin
            num_pix_r  <= num_pix;
            num_pass_r <= num_pass;
            pass_cnt_r <= {PASS_WIDTH{1'b0}};
        end else if ((state_r == ST_ACC) && in_valid && wr_last_s) begin
            pass_cnt_r <= pass_cnt_r + PASS_ONE;
        end
    end

    // Readout word capture and hold until the downstream handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= {WORD_W{1'b0}};
            out_addr_r  <= {ADDR_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RD_WAIT: begin
                    out_data_r  <= buf_final_out;
                    out_addr_r  <= rd_ptr_s;
                    out_valid_r <= 1'b1;
                end
                ST_RD_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    // Buffer address select: write pointer while accumulating, read pointer during readout
    always_comb begin
        buf_addr = {ADDR_WIDTH{1'b0}};
        case (state_r)
            ST_ACC:      buf_addr = wr_ptr_s;
            ST_RD_ISSUE: buf_addr = rd_ptr_s;
            ST_RD_WAIT:  buf_addr = rd_ptr_s;
            ST_RD_HOLD:  buf_addr = rd_ptr_s;
            default:     buf_addr = {ADDR_WIDTH{1'b0}};
        endcase
    end

    assign busy           = (state_r != ST_IDLE);
    assign done           = (state_r == ST_DONE);
    assign in_ready       = (state_r == ST_ACC);
    assign buf_acc_enable = in_valid & in_ready;
    assign buf_acc_clear  = in_ready & (pass_cnt_r == {PASS_WIDTH{1'b0}});
    assign out_data       = out_data_r;
    assign out_addr       = out_addr_r;
    assign out_valid      = out_valid_r;

`ifdef PSUM_CTRL_PERF_EN
    logic [31:0] perf_acc_stall_r;
    logic [31:0] perf_out_stall_r;

    // Stall counters: cleared on an accepted start, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_acc_stall_r <= 32'd0;
            perf_out_stall_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            perf_acc_stall_r <= 32'd0;
            perf_out_stall_r <= 32'd0;
        end else begin
            if ((state_r == ST_ACC) && !in_valid && (perf_acc_stall_r != {32{1'b1}})) begin
                perf_acc_stall_r <= perf_acc_stall_r + 32'd1;
            end
            if ((state_r == ST_RD_HOLD) && !out_ready && (perf_out_stall_r != {32{1'b1}})) begin
                perf_out_stall_r <= perf_out_stall_r + 32'd1;
            end
        end
    end

    assign perf_acc_stall = perf_acc_stall_r;
    assign perf_out_stall = perf_out_stall_r;
`endif

endmodule

// File: tb/tb_psum_buffer_ctrl.sv
// Self-checking bench for psum_buffer_ctrl. A simple buffer model answers
// the controller's reads; the expected readout is derived from the job
// arithmetic (beat k lands at address k % num_pix in pass k / num_pix,
// pass 0 overwrites, later passes add lane-wise).
module tb_psum_buffer_ctrl;

    localparam int AD    = 16;
    localparam int AW    = 32;
    localparam int ADW   = 10;
    localparam int PW    = 8;
    localparam int NPW   = ADW + 1;
    localparam int WW    = AD * AW;
    localparam int DEPTH = 1 << ADW;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [ADW:0]   num_pix;
    logic [PW-1:0]  num_pass;
    logic           busy;
    logic           done;
    logic           in_valid;
    logic           in_ready;
    logic [ADW-1:0] buf_addr;
    logic           buf_acc_enable;
    logic           buf_acc_clear;
    logic [WW-1:0]  buf_final_out;
    logic [WW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic [ADW-1:0] out_addr;
    logic [WW-1:0]  psum_in;

    int checks   = 0;
    int failures = 0;
    int beat_cyc[$];
    int done_cyc;
    int hold_cnt;
    int stall_cnt;
    logic [WW-1:0] mem     [DEPTH];
    logic [WW-1:0] exp_mem [DEPTH];
    logic [WW-1:0] obs_mem [DEPTH];

    always #5 clk = ~clk;

    psum_buffer_ctrl #(
        .ARRAY_DIM (AD),
        .ACC_WIDTH (AW),
        .ADDR_WIDTH(ADW),
        .PASS_WIDTH(PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_pix       (num_pix),
        .num_pass      (num_pass),
        .busy          (busy),
        .done          (done),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .buf_addr      (buf_addr),
        .buf_acc_enable(buf_acc_enable),
        .buf_acc_clear (buf_acc_clear),
        .buf_final_out (buf_final_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr)
    );

    function automatic logic [WW-1:0] lane_add(input logic [WW-1:0] a, input logic [WW-1:0] b);
        logic [WW-1:0] r;
        for (int l = 0; l < AD; l++) r[l*AW +: AW] = a[l*AW +: AW] + b[l*AW +: AW];
        return r;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] r;
        for (int l = 0; l < AD; l++) r[l*AW +: AW] = $urandom();
        return r;
    endfunction

    // Buffer stand-in: writes on an enabled edge, registered read of buf_addr
    always @(posedge clk) begin
        if (buf_acc_enable === 1'b1)
            mem[buf_addr] <= (buf_acc_clear === 1'b1) ? psum_in : lane_add(mem[buf_addr], psum_in);
        buf_final_out <= mem[buf_addr];
    end

    // vmode: 0 in_valid always high, 1 random. rmode: 0 ready high, 1 random, 2 stall word 2 for 5 cycles.
    // dmode: 0 random words, 1 every lane = 5. spur: random start pulses while busy.
    task automatic run_job(input int np, input int npp, input int vmode, input int rmode,
                           input int dmode, input bit spur);
        int k, words, budget, exp_beats, exp_words, p, a;
        bit done_seen, prev_hold;
        logic [WW-1:0]  prev_data;
        logic [ADW-1:0] prev_addr;
        k = 0; words = 0; done_seen = 1'b0; prev_hold = 1'b0; done_cyc = -1;
        hold_cnt = 0; stall_cnt = 0; prev_data = '0; prev_addr = '0;
        beat_cyc.delete();
        exp_beats = np * npp;
        exp_words = (np != 0 && npp != 0) ? np : 0;
        budget    = exp_beats * 8 + np * 12 + 50;
        num_pix   = NPW'(np);
        num_pass  = PW'(npp);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b expected 1", busy);
        if (busy !== 1'b1) failures++;
        for (int c = 0; c < budget && !done_seen; c++) begin
            in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
            psum_in  = (dmode == 1) ? {AD{32'd5}} : rand_word();
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(1, 0));
                default: begin
                    if (out_valid === 1'b1 && words == 2 && stall_cnt < 5) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (spur && $urandom_range(7, 0) == 0) begin
                start    = 1'b1;
                num_pix  = NPW'($urandom_range(DEPTH, 1));
                num_pass = PW'($urandom_range(5, 0));
            end else begin
                start = 1'b0;
            end
            #1;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = c;
            end else begin
                checks++;
                if (buf_acc_enable !== (in_valid & in_ready)) begin
                    failures++;
                    $display("FAIL acc_enable_gate: got %b expected %b", buf_acc_enable, in_valid & in_ready);
                end
                if (buf_acc_enable === 1'b1) begin
                    checks++;
                    if (k >= exp_beats) begin
                        failures++;
                        $display("FAIL extra_beat: got beat %0d expected at most %0d beats", k + 1, exp_beats);
                    end else begin
                        p = k / np;
                        a = k % np;
                        checks++;
                        if (buf_addr !== a[ADW-1:0]) begin
                            failures++;
                            $display("FAIL beat_addr: got %0d expected %0d (beat %0d)", buf_addr, a, k);
                        end
                        checks++;
                        if (buf_acc_clear !== (p == 0)) begin
                            failures++;
                            $display("FAIL acc_clear: got %b expected %b (beat %0d)", buf_acc_clear, (p == 0), k);
                        end
                        exp_mem[a] = (p == 0) ? psum_in : lane_add(exp_mem[a], psum_in);
                    end
                    beat_cyc.push_back(c);
                    k++;
                end
                if (prev_hold) begin
                    hold_cnt++;
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== prev_data || out_addr !== prev_addr) begin
                        failures++;
                        $display("FAIL hold_stable: got valid=%b addr=%0d expected valid=1 addr=%0d", out_valid, out_addr, prev_addr);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (words >= exp_words) begin
                        failures++;
                        $display("FAIL extra_word: got word %0d expected %0d words", words + 1, exp_words);
                    end else begin
                        checks++;
                        if (out_addr !== words[ADW-1:0]) begin
                            failures++;
                            $display("FAIL out_addr: got %0d expected %0d", out_addr, words);
                        end
                        checks++;
                        if (out_data !== exp_mem[words]) begin
                            failures++;
                            $display("FAIL out_data: addr %0d got %h expected %h", words, out_data, exp_mem[words]);
                        end
                        checks++;
                        if (k != exp_beats) begin
                            failures++;
                            $display("FAIL early_readout: got %0d beats expected %0d", k, exp_beats);
                        end
                        obs_mem[words] = out_data;
                    end
                    words++;
                    prev_hold = 1'b0;
                end else if (out_valid === 1'b1) begin
                    prev_hold = 1'b1;
                    prev_data = out_data;
                    prev_addr = out_addr;
                end else begin
                    prev_hold = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
        end
        checks++;
        if (k != exp_beats) begin
            failures++;
            $display("FAIL beat_count: got %0d expected %0d", k, exp_beats);
        end
        checks++;
        if (words != exp_words) begin
            failures++;
            $display("FAIL word_count: got %0d expected %0d", words, exp_words);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_done: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_pix = '0; num_pass = '0;
        in_valid = 1'b1; out_ready = 1'b1; psum_in = '0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({busy, done, in_ready, buf_acc_enable, buf_acc_clear, out_valid} !== 6'b0 ||
            buf_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b rdy=%b en=%b clr=%b ov=%b addr=%0d expected all 0",
                     busy, done, in_ready, buf_acc_enable, buf_acc_clear, out_valid, buf_addr);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_pass();
        run_job(4, 1, 0, 0, 0, 1'b0);
        checks++;
        if (beat_cyc.size() != 4 || beat_cyc[3] - beat_cyc[0] != 3) begin
            failures++;
            $display("FAIL single_pass_beats: got %0d beats expected 4 back to back", beat_cyc.size());
        end
    endtask

    task automatic test_multi_pass();
        for (int a = 0; a < 3; a++) obs_mem[a] = '0;
        run_job(3, 3, 0, 0, 1, 1'b0);
        for (int a = 0; a < 3; a++) begin
            for (int l = 0; l < AD; l += AD - 1) begin
                checks++;
                if (obs_mem[a][l*AW +: AW] !== 32'd15) begin
                    failures++;
                    $display("FAIL multi_pass_sum: addr %0d lane %0d got %0d expected 15", a, l, obs_mem[a][l*AW +: AW]);
                end
            end
        end
    endtask

    task automatic test_bubble();
        obs_mem[0] = '0;
        run_job(1, 4, 0, 0, 1, 1'b0);
        checks++;
        if (beat_cyc.size() != 4) begin
            failures++;
            $display("FAIL bubble_beats: got %0d beats expected 4", beat_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beat_cyc[i+1] - beat_cyc[i] != 2) begin
                    failures++;
                    $display("FAIL bubble_gap: got gap %0d expected 2 (pass %0d)", beat_cyc[i+1] - beat_cyc[i], i);
                end
            end
        end
        checks++;
        if (obs_mem[0][AW-1:0] !== 32'd20) begin
            failures++;
            $display("FAIL bubble_sum: got %0d expected 20", obs_mem[0][AW-1:0]);
        end
    endtask

    task automatic test_backpressure();
        run_job(5, 2, 1, 2, 0, 1'b0);
        checks++;
        if (stall_cnt != 5 || hold_cnt != 5) begin
            failures++;
            $display("FAIL backpressure_hold: got stall=%0d hold=%0d expected 5 5", stall_cnt, hold_cnt);
        end
    endtask

    task automatic test_zero_and_busy_start();
        run_job(0, 3, 1, 1, 0, 1'b0);
        checks++;
        if (done_cyc != 0) begin
            failures++;
            $display("FAIL zero_pix_done: got cycle %0d expected 0", done_cyc);
        end
        run_job(4, 0, 1, 1, 0, 1'b0);
        checks++;
        if (done_cyc != 0) begin
            failures++;
            $display("FAIL zero_pass_done: got cycle %0d expected 0", done_cyc);
        end
        run_job(6, 2, 1, 1, 0, 1'b1);
    endtask

    task automatic test_mid_reset();
        num_pix = NPW'(4); num_pass = PW'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            psum_in = rand_word();
            @(posedge clk); #1;
        end
        checks++;
        if (buf_addr !== 10'd2 || buf_acc_clear !== 1'b0 || buf_acc_enable !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_beat: got addr=%0d clr=%b en=%b expected 2 0 1", buf_addr, buf_acc_clear, buf_acc_enable);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, in_ready, buf_acc_enable, buf_acc_clear, out_valid} !== 6'b0 ||
            buf_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b rdy=%b en=%b addr=%0d expected all 0", busy, in_ready, buf_acc_enable, buf_addr);
        end
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        run_job(4, 1, 1, 0, 0, 1'b0);
    endtask

    task automatic test_max_and_random();
        run_job(DEPTH, 1, 1, 1, 0, 1'b0);
        for (int j = 0; j < 4; j++)
            run_job($urandom_range(20, 1), $urandom_range(4, 1), 1, 1, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_bubble();
        test_backpressure();
        test_zero_and_busy_start();
        test_mid_reset();
        test_max_and_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
